// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: two request/response ports
// (0 = instruction fetch, 1 = data load/store).
interface mem_port_arbiter_if #(parameter int ADDR_W = 16);
  logic              req0, req1;
  logic              we0, we1;
  logic              wide0, wide1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [15:0]       wdata0, wdata1;
  logic              ack0, ack1;
  logic [15:0]       rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, wide0, wide1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, wide0, wide1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto a single-port byte memory; 16-bit words run as two byte accesses.
// Define MEM_ARB_FIXED_PRIO_EN to give port 1 fixed priority instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter bit RR_INIT_LAST = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [7:0]         mem_writeData,
  output logic               mem_writeEnable,
  input  logic [7:0]         mem_readData
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;

  typedef struct packed {
    logic              we;
    logic              wide;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } req_t;

  logic [1:0]  state;
  logic        owner;
  req_t        cur, sel;
  logic [7:0]  rbuf;
  logic [1:0]  vreq;
  logic        gnt;
  logic        done;
  logic [15:0] rd_val;

  // A port's req is ignored during its own ack cycle so it has time to drop.
  assign vreq = {bus.req1 & ~bus.ack1, bus.req0 & ~bus.ack0};

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign gnt = vreq[1];
`else
  logic last_grant;
  assign gnt = vreq[1] & (~vreq[0] | ~last_grant);
`endif

  always_comb begin
    if (gnt) sel = '{we: bus.we1, wide: bus.wide1, addr: bus.addr1, wdata: bus.wdata1};
    else     sel = '{we: bus.we0, wide: bus.wide0, addr: bus.addr0, wdata: bus.wdata0};
  end

  // Memory side is a pure decode of state and latched request.
  always_comb begin
    mem_address     = '0;
    mem_writeData   = '0;
    mem_writeEnable = 1'b0;
    case (state)
      ACC0: begin
        mem_address     = cur.addr;
        mem_writeData   = cur.wdata[7:0];
        mem_writeEnable = cur.we;
      end
      ACC1: begin
        mem_address     = cur.addr + ADDR_W'(1);
        mem_writeData   = cur.wdata[15:8];
        mem_writeEnable = cur.we;
      end
      default: ;
    endcase
  end

  assign done   = (state == ACC0 && !cur.wide) || (state == ACC1);
  assign rd_val = (state == ACC1) ? {mem_readData, rbuf} : {8'h00, mem_readData};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cur        <= '0;
      rbuf       <= '0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant <= RR_INIT_LAST;
`endif
    end else begin
      bus.ack0 <= done & ~owner;
      bus.ack1 <= done & owner;
      if (done && !cur.we && !owner) bus.rdata0 <= rd_val;
      if (done && !cur.we &&  owner) bus.rdata1 <= rd_val;
      case (state)
        IDLE: if (|vreq) begin
          cur   <= sel;
          owner <= gnt;
          state <= ACC0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_grant <= gnt;
`endif
        end
        ACC0: begin
          rbuf  <= mem_readData;
          state <= cur.wide ? ACC1 : IDLE;
        end
        ACC1:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
